// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel renderers and VGA DAC.
interface vga_timing_gen_if #(
  parameter int CW      = 10,
  parameter int FRAME_W = 16
);
  logic               pix_en;
  logic [CW-1:0]      h_count;
  logic [CW-1:0]      v_count;
  logic               display_area;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output pix_en, h_count, v_count, display_area, hsync, vsync,
           line_start, frame_start, frame_count
  );

  modport slave (
    input pix_en, h_count, v_count, display_area, hsync, vsync,
          line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametric VGA raster timing generator with a pixel enable on the system clock,
// run/pause gating, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FRAME_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Window bounds are one bit wider than the counters so an end bound equal to
  // the total (zero back porch) still compares correctly.
  localparam logic [CW:0]   H_ACT_C   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   V_ACT_C   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   HS_START_C = (CW+1)'(HS_START);
  localparam logic [CW:0]   HS_END_C   = (CW+1)'(HS_END);
  localparam logic [CW:0]   VS_START_C = (CW+1)'(VS_START);
  localparam logic [CW:0]   VS_END_C   = (CW+1)'(VS_END);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  // Reject parameter sets the counters cannot represent.
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_check
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [DW-1:0]      div_cnt_reg, div_cnt_next;
  logic [CW-1:0]      h_count_reg, h_count_next;
  logic [CW-1:0]      v_count_reg, v_count_next;
  logic [FRAME_W-1:0] frame_count_reg, frame_count_next;
  logic               pix_en_reg, pix_en_next;
  logic               line_start_reg, line_start_next;
  logic               frame_start_reg, frame_start_next;
  logic               display_area_reg, display_area_next;
  logic               hsync_reg, hsync_next;
  logic               vsync_reg, vsync_next;
  logic [CW:0]        h_ext, v_ext;

  // Next-state counters; decoded outputs come from the next counters so they
  // line up with the h/v values presented in the same cycle.
  always_comb begin
    div_cnt_next      = div_cnt_reg;
    h_count_next      = h_count_reg;
    v_count_next      = v_count_reg;
    frame_count_next  = frame_count_reg;
    pix_en_next       = 1'b0;
    line_start_next   = 1'b0;
    frame_start_next  = 1'b0;

    if (en) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_next = '0;
        pix_en_next  = 1'b1;
        if (h_count_reg == H_LAST) begin
          h_count_next    = '0;
          line_start_next = 1'b1;
          if (v_count_reg == V_LAST) begin
            v_count_next     = '0;
            frame_start_next = 1'b1;
            frame_count_next = frame_count_reg + FRAME_W'(1);
          end else begin
            v_count_next = v_count_reg + CW'(1);
          end
        end else begin
          h_count_next = h_count_reg + CW'(1);
        end
      end else begin
        div_cnt_next = div_cnt_reg + DW'(1);
      end
    end

    h_ext             = {1'b0, h_count_next};
    v_ext             = {1'b0, v_count_next};
    display_area_next = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
    hsync_next        = ((h_ext >= HS_START_C) && (h_ext < HS_END_C)) ? HS_POL : ~HS_POL;
    vsync_next        = ((v_ext >= VS_START_C) && (v_ext < VS_END_C)) ? VS_POL : ~VS_POL;
  end

  // State and output registers; reset parks the raster on the last pixel so the
  // first pixel strobe lands on (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg      <= '0;
      h_count_reg      <= H_LAST;
      v_count_reg      <= V_LAST;
      frame_count_reg  <= '0;
      pix_en_reg       <= 1'b0;
      line_start_reg   <= 1'b0;
      frame_start_reg  <= 1'b0;
      display_area_reg <= 1'b0;
      hsync_reg        <= ~HS_POL;
      vsync_reg        <= ~VS_POL;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      h_count_reg      <= h_count_next;
      v_count_reg      <= v_count_next;
      frame_count_reg  <= frame_count_next;
      pix_en_reg       <= pix_en_next;
      line_start_reg   <= line_start_next;
      frame_start_reg  <= frame_start_next;
      display_area_reg <= display_area_next;
      hsync_reg        <= hsync_next;
      vsync_reg        <= vsync_next;
    end
  end

  assign vga.pix_en       = pix_en_reg;
  assign vga.h_count      = h_count_reg;
  assign vga.v_count      = v_count_reg;
  assign vga.display_area = display_area_reg;
  assign vga.hsync        = hsync_reg;
  assign vga.vsync        = vsync_reg;
  assign vga.line_start   = line_start_reg;
  assign vga.frame_start  = frame_start_reg;
  assign vga.frame_count  = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 12x7 instance,
// both checked every cycle against a raster model derived from the count of
// enabled clocks since reset, plus literal spot checks.
module tb_vga_timing_gen;

  localparam int CW = 10, FW = 16;
  localparam int S_CW = 4, S_FW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, en0 = 1'b0;
  logic rst1 = 1'b1, en1 = 1'b0;
  int   cyc = 0;

  vga_timing_gen_if #(.CW(CW),   .FRAME_W(FW))   bus0();
  vga_timing_gen_if #(.CW(S_CW), .FRAME_W(S_FW)) bus1();

  vga_timing_gen dut0 (.clk(clk), .rst(rst0), .en(en0), .vga(bus0));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(S_CW), .FRAME_W(S_FW)
  ) dut1 (.clk(clk), .rst(rst1), .en(en1), .vga(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int pix, h, v, disp, hs, vs, ls, fs, fc;
  } exp_t;

  // Raster position is (pixel strobes since reset - 1) modulo the frame size;
  // reset state is that index at -1, i.e. the last pixel of the last line.
  function automatic exp_t model(input longint e, input bit pe, input int cd,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int hpol, input int vpol, input int fw);
    exp_t   x;
    longint ht, vt, t, n, pos;
    ht    = ha + hf + hs + hb;
    vt    = va + vf + vs + vb;
    t     = ht * vt;
    n     = e / cd;
    pos   = (n + t - 1) % t;
    x.h   = int'(pos % ht);
    x.v   = int'(pos / ht);
    x.fc  = int'(((n + t - 1) / t) % (longint'(1) << fw));
    x.pix = (pe && (e % cd == 0)) ? 1 : 0;
    x.disp = (x.h < ha && x.v < va) ? 1 : 0;
    x.hs  = (x.h >= ha + hf && x.h < ha + hf + hs) ? hpol : 1 - hpol;
    x.vs  = (x.v >= va + vf && x.v < va + vf + vs) ? vpol : 1 - vpol;
    x.ls  = (x.pix == 1 && x.h == 0) ? 1 : 0;
    x.fs  = (x.pix == 1 && pos == 0) ? 1 : 0;
    return x;
  endfunction

  // Model state: enabled clocks since last reset, and whether the last edge counted.
  longint e0 = 0, e1 = 0;
  bit pe0 = 1'b0, pe1 = 1'b0, started0 = 1'b0, started1 = 1'b0;

  // Advance the model on each clock edge from the same inputs the DUTs see.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst0) begin e0 <= 0; pe0 <= 1'b0; started0 <= 1'b1; end
    else if (en0) begin e0 <= e0 + 1; pe0 <= 1'b1; end
    else pe0 <= 1'b0;
    if (rst1) begin e1 <= 0; pe1 <= 1'b0; started1 <= 1'b1; end
    else if (en1) begin e1 <= e1 + 1; pe1 <= 1'b1; end
    else pe1 <= 1'b0;
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    exp_t x;
    if (started0) begin
      x = model(e0, pe0, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, FW);
      cmp("d0_pix_en", bus0.pix_en, x.pix);
      cmp("d0_h", bus0.h_count, x.h);
      cmp("d0_v", bus0.v_count, x.v);
      cmp("d0_disp", bus0.display_area, x.disp);
      cmp("d0_hsync", bus0.hsync, x.hs);
      cmp("d0_vsync", bus0.vsync, x.vs);
      cmp("d0_line_start", bus0.line_start, x.ls);
      cmp("d0_frame_start", bus0.frame_start, x.fs);
      cmp("d0_frame_count", bus0.frame_count, x.fc);
    end
    if (started1) begin
      x = model(e1, pe1, 1, 8, 1, 2, 1, 4, 1, 1, 1, 1, 0, S_FW);
      cmp("d1_pix_en", bus1.pix_en, x.pix);
      cmp("d1_h", bus1.h_count, x.h);
      cmp("d1_v", bus1.v_count, x.v);
      cmp("d1_disp", bus1.display_area, x.disp);
      cmp("d1_hsync", bus1.hsync, x.hs);
      cmp("d1_vsync", bus1.vsync, x.vs);
      cmp("d1_line_start", bus1.line_start, x.ls);
      cmp("d1_frame_start", bus1.frame_start, x.fs);
      cmp("d1_frame_count", bus1.frame_count, x.fc);
    end
  end

  bit done1 = 1'b0;

  // Small instance: frame period, frame_count wrap, then random en/rst.
  initial begin
    int fcs[4] = '{1, 2, 3, 0};
    int frames, last, k;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    en1  = 1'b1;
    frames = 0; last = -1; k = 0;
    while (frames < 4 && k < 500) begin
      @(negedge clk);
      k++;
      if (bus1.frame_start) begin
        cmp("d1_fc_seq", bus1.frame_count, fcs[frames]);
        if (last >= 0) cmp("d1_frame_period", cyc - last, 84);
        last = cyc;
        frames++;
      end
      if (bus1.pix_en && bus1.h_count == 9) cmp("d1_hsync_h9", bus1.hsync, 1);
      if (bus1.pix_en && bus1.h_count == 11) cmp("d1_hsync_h11", bus1.hsync, 0);
      if (bus1.pix_en && bus1.v_count == 5) cmp("d1_vsync_v5", bus1.vsync, 0);
    end
    if (frames < 4) cmp("d1_frames_timeout", frames, 4);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst1 = ($urandom_range(0, 149) == 0);
      en1  = ($urandom_range(0, 3) != 0);
    end
    rst1 = 1'b0;
    en1  = 1'b0;
    done1 = 1'b1;
  end

  // Default instance: reset state, first pixel, line period, pause, mid-line reset, random.
  initial begin
    int k, last, fc_hold;
    repeat (3) @(negedge clk);
    cmp("d0_rst_h", bus0.h_count, 799);
    cmp("d0_rst_v", bus0.v_count, 524);
    cmp("d0_rst_hsync", bus0.hsync, 1);
    cmp("d0_rst_fc", bus0.frame_count, 0);
    rst0 = 1'b0;
    en0  = 1'b1;

    k = 0;
    do begin @(negedge clk); k++; end while (!bus0.pix_en && k < 10);
    cmp("d0_first_pix_latency", k, 2);
    cmp("d0_first_h", bus0.h_count, 0);
    cmp("d0_first_v", bus0.v_count, 0);
    cmp("d0_first_ls", bus0.line_start, 1);
    cmp("d0_first_fs", bus0.frame_start, 1);
    cmp("d0_first_fc", bus0.frame_count, 1);
    cmp("d0_first_disp", bus0.display_area, 1);

    last = cyc;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus0.line_start && k < 2000);
    cmp("d0_line_period", cyc - last, 1600);
    cmp("d0_line2_v", bus0.v_count, 1);

    k = 0;
    while (!(bus0.pix_en && bus0.h_count == 300) && k < 1000) begin @(negedge clk); k++; end
    cmp("d0_reach_h300", bus0.h_count, 300);
    fc_hold = int'(bus0.frame_count);
    en0 = 1'b0;
    repeat (37) begin
      @(negedge clk);
      cmp("d0_pause_pix", bus0.pix_en, 0);
      cmp("d0_pause_h", bus0.h_count, 300);
    end
    cmp("d0_pause_fc", bus0.frame_count, fc_hold);
    en0 = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus0.pix_en && k < 5);
    cmp("d0_resume_latency", k, 2);
    cmp("d0_resume_h", bus0.h_count, 301);

    k = 0;
    while (!(bus0.pix_en && bus0.h_count == 400) && k < 1000) begin @(negedge clk); k++; end
    cmp("d0_reach_h400", bus0.h_count, 400);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    cmp("d0_mrst_h", bus0.h_count, 799);
    cmp("d0_mrst_v", bus0.v_count, 524);
    cmp("d0_mrst_hsync", bus0.hsync, 1);
    cmp("d0_mrst_vsync", bus0.vsync, 1);
    cmp("d0_mrst_ls", bus0.line_start, 0);
    cmp("d0_mrst_fs", bus0.frame_start, 0);
    cmp("d0_mrst_fc", bus0.frame_count, 0);

    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      rst0 = ($urandom_range(0, 2999) == 0);
      en0  = ($urandom_range(0, 7) != 0);
    end
    rst0 = 1'b0;
    en0  = 1'b0;
    k = 0;
    while (!done1 && k < 20000) begin @(negedge clk); k++; end
    if (!done1) cmp("d1_done_timeout", 0, 1);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
